// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: opcodes, FSM states and the
// opcode that needs divide-by-zero screening.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_EQ  = 3'b101,
      OP_MUL = 3'b110,
      OP_DIV = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_RESP    = 2'd3
   } seq_state_e;

   localparam alu_op_e DIV_OPCODE = OP_DIV;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Initiator for the ALU operand/select/enable interface: takes one command,
// drives the ALU for a cycle, captures result and flags, returns a response.
import alu_pkg::*;

module alu_cmd_sequencer #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned TAG_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [WIDTH-1:0]     cmd_a,
   input  logic [WIDTH-1:0]     cmd_b,
   input  logic [2:0]           cmd_op,
   output logic [WIDTH-1:0]     alu_a,
   output logic [WIDTH-1:0]     alu_b,
   output logic [2:0]           alu_select,
   output logic                 alu_enable,
   input  logic [2*WIDTH-1:0]   alu_out,
   input  logic                 alu_carry,
   input  logic                 alu_greater,
   input  logic                 alu_equal,
   input  logic                 alu_less,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [2*WIDTH-1:0]   rsp_result,
   output logic                 rsp_carry,
   output logic [2:0]           rsp_flags,
   output logic [2:0]           rsp_op,
   output logic [TAG_W-1:0]     rsp_tag,
   output logic                 rsp_err
);

   localparam int unsigned RES_W = 2 * WIDTH;

   seq_state_e         r_state;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   alu_op_e            r_op;
   logic               r_enable;
   logic               r_rsp_valid;
   logic [RES_W-1:0]   r_result;
   logic               r_carry;
   logic [2:0]         r_flags;
   logic [2:0]         r_rsp_op;
   logic               r_err;
   logic [TAG_W-1:0]   r_tag;

   logic               w_idle;
   logic               w_div0;

   assign w_idle = (r_state == ST_IDLE);
   assign w_div0 = (alu_op_e'(cmd_op) == DIV_OPCODE) && (cmd_b == '0);

   // Ready is a state decode, forced low while reset is held.
   assign cmd_ready  = w_idle & ~rst;

   assign alu_a      = r_a;
   assign alu_b      = r_b;
   assign alu_select = r_op;
   assign alu_enable = r_enable;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_result = r_result;
   assign rsp_carry  = r_carry;
   assign rsp_flags  = r_flags;
   assign rsp_op     = r_rsp_op;
   assign rsp_tag    = r_tag;
   assign rsp_err    = r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_op        <= OP_ADD;
         r_enable    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_result    <= '0;
         r_carry     <= 1'b0;
         r_flags     <= 3'b000;
         r_rsp_op    <= 3'b000;
         r_err       <= 1'b0;
         r_tag       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  r_a  <= cmd_a;
                  r_b  <= cmd_b;
                  r_op <= alu_op_e'(cmd_op);
                  // Divide-by-zero never reaches the ALU; answer locally.
                  if (w_div0) begin
                     r_result    <= '0;
                     r_carry     <= 1'b0;
                     r_flags     <= {cmd_a > cmd_b, cmd_a == cmd_b, cmd_a < cmd_b};
                     r_rsp_op    <= cmd_op;
                     r_err       <= 1'b1;
                     r_rsp_valid <= 1'b1;
                     r_state     <= ST_RESP;
                  end else begin
                     r_enable <= 1'b1;
                     r_state  <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               r_enable <= 1'b0;
               r_state  <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               // ALU result is registered by now; flags still follow held operands.
               r_result    <= alu_out;
               r_carry     <= alu_carry;
               r_flags     <= {alu_greater, alu_equal, alu_less};
               r_rsp_op    <= r_op;
               r_err       <= 1'b0;
               r_rsp_valid <= 1'b1;
               r_state     <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_tag       <= r_tag + TAG_W'(1);
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural ALU attached.
module tb_alu_cmd_sequencer;

   localparam int W  = 4;
   localparam int TW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [W-1:0]  cmd_a = '0;
   logic [W-1:0]  cmd_b = '0;
   logic [2:0]    cmd_op = '0;
   logic [W-1:0]  alu_a;
   logic [W-1:0]  alu_b;
   logic [2:0]    alu_select;
   logic          alu_enable;
   logic [2*W-1:0] alu_out = '0;
   logic          alu_carry;
   logic          alu_greater;
   logic          alu_equal;
   logic          alu_less;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [2*W-1:0] rsp_result;
   logic          rsp_carry;
   logic [2:0]    rsp_flags;
   logic [2:0]    rsp_op;
   logic [TW-1:0] rsp_tag;
   logic          rsp_err;

   alu_cmd_sequencer #(.WIDTH(W), .TAG_W(TW)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_enable(alu_enable),
      .alu_out(alu_out), .alu_carry(alu_carry),
      .alu_greater(alu_greater), .alu_equal(alu_equal), .alu_less(alu_less),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_flags(rsp_flags),
      .rsp_op(rsp_op), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   // Behavioural ALU: registered result, combinational carry and compare flags.
   function automatic logic [2*W-1:0] alu_f(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op);
      case (op)
         3'd0: return {4'b0, a} + {4'b0, b};
         3'd1: return {4'b0, 4'(a - b)};
         3'd2: return {4'b0, a & b};
         3'd3: return {4'b0, a | b};
         3'd4: return {4'b0, a ^ b};
         3'd5: return (a == b) ? 8'd1 : 8'd0;
         3'd6: return {4'b0, a} * {4'b0, b};
         default: return (b == 0) ? 8'd0 : {4'b0, 4'(a / b)};
      endcase
   endfunction

   logic [W:0] alu_sum;
   assign alu_sum     = {1'b0, alu_a} + {1'b0, alu_b};
   assign alu_carry   = alu_sum[W];
   assign alu_greater = alu_a > alu_b;
   assign alu_equal   = alu_a == alu_b;
   assign alu_less    = alu_a < alu_b;
   always @(posedge clk) if (alu_enable) alu_out <= alu_f(alu_a, alu_b, alu_select);

   typedef struct {
      logic [7:0] result;
      logic       carry;
      logic [2:0] flags;
      logic [2:0] op;
      logic [1:0] tag;
      logic       err;
      int         first_cyc;
      int         n_en;
   } exp_t;

   exp_t q[$];
   logic [TW-1:0] tag_m = '0;
   int bp_hold = 0;

   // Reference response computed with integer arithmetic from the opcode table.
   function automatic exp_t ref_model(int a, int b, int op);
      exp_t e;
      int r;
      bit d0 = (op == 7) && (b == 0);
      case (op)
         0: r = a + b;
         1: r = (a - b) & 15;
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = (a == b) ? 1 : 0;
         6: r = a * b;
         default: r = d0 ? 0 : a / b;
      endcase
      e.result    = 8'(r);
      e.carry     = d0 ? 1'b0 : ((a + b) > 15);
      e.flags     = {a > b, a == b, a < b};
      e.op        = 3'(op);
      e.err       = d0;
      e.tag       = '0;
      e.first_cyc = d0 ? 1 : 3;
      e.n_en      = d0 ? 0 : 1;
      return e;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic issue(int a, int b, int op, bit push);
      int n = 0;
      exp_t e;
      @(negedge clk);
      cmd_a = 4'(a); cmd_b = 4'(b); cmd_op = 3'(op); cmd_valid = 1'b1;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         checks++; errors++;
         $display("FAIL cmd_ready_timeout: got 0 expected 1 after 50 cycles");
         cmd_valid = 1'b0;
         return;
      end
      if (push) begin
         e = ref_model(a, b, op);
         e.tag = tag_m;
         e.first_cyc = cyc + e.first_cyc;
         q.push_back(e);
         tag_m = tag_m + 2'd1;
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 3'($urandom);
   endtask

   // Monitor: pops the expectation when a response appears and checks it each cycle.
   initial begin
      bit   active = 0;
      bit   acc_prev = 0;
      int   en_cnt = 0;
      exp_t cur;
      forever begin
         @(negedge clk);
         if (rst) begin
            active = 0; acc_prev = 0; en_cnt = 0; rsp_ready = 1'b0;
         end else begin
            if (acc_prev) begin
               chk("valid_after_accept", rsp_valid, 0);
               chk("ready_after_accept", cmd_ready, 1);
               acc_prev = 0;
            end
            if (alu_enable) en_cnt++;
            if (rsp_valid) begin
               if (!active) begin
                  if (q.size() == 0) begin
                     checks++; errors++;
                     $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
                  end else begin
                     cur = q.pop_front();
                     active = 1;
                     chk("latency", cyc, cur.first_cyc);
                     chk("enable_cycles", en_cnt, cur.n_en);
                  end
                  en_cnt = 0;
               end
               if (active) begin
                  chk("rsp_result", rsp_result, cur.result);
                  chk("rsp_carry", rsp_carry, cur.carry);
                  chk("rsp_flags", rsp_flags, cur.flags);
                  chk("rsp_op", rsp_op, cur.op);
                  chk("rsp_tag", rsp_tag, cur.tag);
                  chk("rsp_err", rsp_err, cur.err);
                  chk("cmd_ready_in_resp", cmd_ready, 0);
               end
               if (bp_hold > 0) begin
                  rsp_ready = 1'b0;
                  bp_hold--;
               end else begin
                  rsp_ready = ($urandom_range(0, 3) != 0);
               end
               if (rsp_ready) begin
                  active = 0;
                  acc_prev = 1;
               end
            end else begin
               rsp_ready = 1'($urandom_range(0, 1));
            end
         end
      end
   end

   initial begin
      int n;
      // Reset values.
      #12;
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_alu_enable", alu_enable, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_rsp_tag", rsp_tag, 0);
      @(posedge clk); #2 rst = 1'b0;
      #1 chk("idle_cmd_ready", cmd_ready, 1);

      // Directed cases.
      issue(9, 8, 0, 1);
      issue(15, 15, 6, 1);
      issue(7, 0, 7, 1);
      issue(13, 4, 7, 1);
      issue(5, 5, 5, 1);
      bp_hold = 5;
      issue(3, 12, 1, 1);
      wait (q.size() == 0);
      repeat (4) @(negedge clk);

      // Reset in the middle of CAPTURE: nothing must come out.
      bp_hold = 0;
      issue(6, 2, 0, 0);
      @(posedge clk);
      #2 rst = 1'b1;
      tag_m = '0;
      #1;
      chk("midrst_rsp_valid", rsp_valid, 0);
      chk("midrst_alu_enable", alu_enable, 0);
      chk("midrst_alu_b", alu_b, 0);
      chk("midrst_rsp_result", rsp_result, 0);
      chk("midrst_rsp_tag", rsp_tag, 0);
      chk("midrst_cmd_ready", cmd_ready, 0);
      @(posedge clk); #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("postrst_rsp_valid", rsp_valid, 0);

      // Back-to-back commands wrap the 2-bit tag: 0,1,2,3,0.
      for (int i = 0; i < 5; i++) issue(i + 1, 2, i % 5, 1);

      // Random traffic including divide-by-zero.
      for (int i = 0; i < 150; i++) begin
         int op = $urandom_range(0, 7);
         int b  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15);
         issue($urandom_range(0, 15), b, op, 1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      chk("drain_queue", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
